snes_pad_poller: RTL and testbench

SNES_PAD_POLLER -- requirements
Module: snes_pad_poller

---
 rtl/snes_pad_pkg.sv | 29 ++
 rtl/edge_event_reg.sv | 44 ++++
 rtl/snes_pad_poller.sv | 188 ++++++++++++++++++
 tb/tb_snes_pad_poller.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_pad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snes_pad_pkg
//  Description : Shared constants and state encoding for the SNES pad poller.
//                Holds default timing parameters, the pad-present signature
//                and the poller FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package snes_pad_pkg;

    // Default automatic poll period: 60 Hz at a 50 MHz system clock.
    localparam int unsigned c_poll_cycles_default    = 833333;
    // Default reader watchdog, in clk cycles spent waiting for done.
    localparam int unsigned c_timeout_cycles_default = 4096;
    // Width of the shifted pad word.
    localparam int unsigned c_pad_width              = 16;
    // A connected pad always shifts out ones (released) in the four
    // trailing unused bit positions; an unplugged port reads back zeros.
    localparam logic [3:0]  c_present_pattern        = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } poll_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_event_reg.sv
`default_nettype none
// ============================================================================
//  Module      : edge_event_reg
//  Description : Sticky per-bit event register. A set bit stays set until
//                its clear bit is pulsed; set wins over clear in the same
//                cycle so no event is ever lost.
//  Ports       : clk   - system clock
//                reset - asynchronous active-low reset
//                set   - per-bit set request
//                clr   - per-bit clear request
//                q     - registered event bits
//  Revision    : 1.0  initial release
// ============================================================================
module edge_event_reg
    import snes_pad_pkg::*;
#(
    parameter int unsigned WIDTH = c_pad_width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = (q_q & ~clr) | set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/snes_pad_poller.sv
`default_nettype none
// ============================================================================
//  Module      : snes_pad_poller
//  Description : Periodically (or on request) triggers an SNES pad reader,
//                waits for its completion with a watchdog, captures the
//                pad word and maintains button state plus sticky press and
//                release event registers with an interrupt on new presses.
//  Ports       : clk          - system clock, rising edge
//                reset        - asynchronous active-low reset
//                frame        - one-cycle start pulse to the reader
//                done         - reader completion level
//                nesState     - raw pad word, active-low, first bit at [15]
//                poll_req     - one-cycle immediate poll request
//                ev_clr       - per-bit clear for both event registers
//                buttons      - captured button state, 1 = pressed
//                pressed_ev   - sticky press events
//                released_ev  - sticky release events
//                present      - pad connected flag
//                timeout_err  - sticky reader timeout flag
//                busy         - poller not idle
//                irq          - one-cycle pulse on any new press event
//  Revision    : 1.0  initial release
// ============================================================================
module snes_pad_poller
    import snes_pad_pkg::*;
#(
    parameter int unsigned POLL_CYCLES    = c_poll_cycles_default,
    parameter int unsigned TIMEOUT_CYCLES = c_timeout_cycles_default
) (
    input  logic        clk,
    input  logic        reset,
    output logic        frame,
    input  logic        done,
    input  logic [15:0] nesState,
    input  logic        poll_req,
    input  logic [15:0] ev_clr,
    output logic [15:0] buttons,
    output logic [15:0] pressed_ev,
    output logic [15:0] released_ev,
    output logic        present,
    output logic        timeout_err,
    output logic        busy,
    output logic        irq
);

    localparam int unsigned c_tick_w = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned c_wait_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(POLL_CYCLES - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_wait_w-1:0] c_wait_one  = c_wait_w'(1);

    poll_state_t         state_q,       state_d;
    logic [c_tick_w-1:0] tick_cnt_q,    tick_cnt_d;
    logic [c_wait_w-1:0] wait_cnt_q,    wait_cnt_d;
    logic                pending_q,     pending_d;
    logic                done_prev_q,   done_prev_d;
    logic [15:0]         buttons_q,     buttons_d;
    logic                present_q,     present_d;
    logic                timeout_err_q, timeout_err_d;
    logic                irq_q,         irq_d;

    logic                w_tick;
    logic                w_trigger;
    logic                w_done_rise;
    logic                w_pad_ok;
    logic [15:0]         w_new;
    logic [15:0]         w_press_set;
    logic [15:0]         w_release_set;

    // Free-running poll timebase; it never pauses while the FSM is busy.
    always_comb begin
        w_tick     = (tick_cnt_q == c_tick_last);
        tick_cnt_d = w_tick ? '0 : (tick_cnt_q + c_tick_one);
    end

    always_comb begin
        w_trigger   = w_tick | poll_req;
        // Edge detect: a done level already high when WAIT is entered has a
        // high history sample and so is ignored until it falls and rises.
        w_done_rise = done & ~done_prev_q;
        done_prev_d = done;
        w_new       = ~nesState;
        w_pad_ok    = (nesState[3:0] == c_present_pattern);
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        buttons_d     = buttons_q;
        present_d     = present_q;
        timeout_err_d = timeout_err_q;
        irq_d         = 1'b0;
        w_press_set   = '0;
        w_release_set = '0;
        // One request slot: it is consumed on leaving IDLE and any further
        // requests while busy collapse into it.
        pending_d     = (state_q == ST_IDLE) ? 1'b0 : (pending_q | w_trigger);

        case (state_q)
            ST_IDLE: begin
                if (w_trigger || pending_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done_rise) begin
                    state_d = ST_CAPTURE;
                end else if (wait_cnt_q == c_wait_last) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + c_wait_one;
                end
            end
            ST_CAPTURE: begin
                present_d     = w_pad_ok;
                timeout_err_d = 1'b0;
                if (w_pad_ok) begin
                    buttons_d     = w_new;
                    w_press_set   = w_new & ~buttons_q;
                    w_release_set = ~w_new & buttons_q;
                end else begin
                    // Unplugged pad: report nothing held and raise no events.
                    buttons_d = '0;
                end
                irq_d   = |(w_press_set & ~pressed_ev);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            tick_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            pending_q     <= 1'b0;
            done_prev_q   <= 1'b0;
            buttons_q     <= '0;
            present_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            pending_q     <= pending_d;
            done_prev_q   <= done_prev_d;
            buttons_q     <= buttons_d;
            present_q     <= present_d;
            timeout_err_q <= timeout_err_d;
            irq_q         <= irq_d;
        end
    end

    edge_event_reg #(.WIDTH(16)) u_pressed_ev (
        .clk   (clk),
        .reset (reset),
        .set   (w_press_set),
        .clr   (ev_clr),
        .q     (pressed_ev)
    );

    edge_event_reg #(.WIDTH(16)) u_released_ev (
        .clk   (clk),
        .reset (reset),
        .set   (w_release_set),
        .clr   (ev_clr),
        .q     (released_ev)
    );

    assign frame       = (state_q == ST_REQ);
    assign busy        = (state_q != ST_IDLE);
    assign buttons     = buttons_q;
    assign present     = present_q;
    assign timeout_err = timeout_err_q;
    assign irq         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_pad_poller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_snes_pad_poller
//  Description : Self-checking bench for snes_pad_poller with a behavioural
//                pad reader and a per-button reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_snes_pad_poller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: tick period far beyond the run, so polls are request-only.
    logic        reset, done, poll_req, frame, busy, irq, present, timeout_err;
    logic [15:0] nes_state, ev_clr, buttons, pressed_ev, released_ev;

    // Second instance: short tick period for timebase and pending tests.
    logic        reset_t, done_t, poll_req_t, frame_t, busy_t, irq_t, present_t, timeout_err_t;
    logic [15:0] nes_state_t, ev_clr_t, buttons_t, pressed_ev_t, released_ev_t;

    snes_pad_poller #(.POLL_CYCLES(1000000), .TIMEOUT_CYCLES(4096)) u_dut (
        .clk(clk), .reset(reset), .frame(frame), .done(done), .nesState(nes_state),
        .poll_req(poll_req), .ev_clr(ev_clr), .buttons(buttons), .pressed_ev(pressed_ev),
        .released_ev(released_ev), .present(present), .timeout_err(timeout_err),
        .busy(busy), .irq(irq)
    );

    snes_pad_poller #(.POLL_CYCLES(100)) u_tick (
        .clk(clk), .reset(reset_t), .frame(frame_t), .done(done_t), .nesState(nes_state_t),
        .poll_req(poll_req_t), .ev_clr(ev_clr_t), .buttons(buttons_t), .pressed_ev(pressed_ev_t),
        .released_ev(released_ev_t), .present(present_t), .timeout_err(timeout_err_t),
        .busy(busy_t), .irq(irq_t)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [15:0] m_buttons, m_pressed, m_released;
    logic        m_present, m_timeout;

    // Observation accumulators for the reader task.
    int obs_irq, obs_busy;

    task automatic model_reset();
        m_buttons = '0; m_pressed = '0; m_released = '0;
        m_present = 1'b0; m_timeout = 1'b0;
    endtask

    // Button-by-button view of one capture; clr is an ev_clr pulse landing
    // in the capture cycle (a new event must survive it).
    task automatic model_capture(input logic [15:0] ns, input logic [15:0] clr, output bit exp_irq);
        logic [15:0] old_p;
        bit pad;
        exp_irq    = 1'b0;
        old_p      = m_pressed;
        pad        = (ns[3:0] == 4'hF);
        m_pressed  = m_pressed & ~clr;
        m_released = m_released & ~clr;
        for (int b = 0; b < 16; b++) begin
            bit held_now;
            held_now = !ns[b];
            if (pad) begin
                if (held_now && !m_buttons[b]) begin
                    if (!old_p[b]) exp_irq = 1'b1;
                    m_pressed[b] = 1'b1;
                end
                if (!held_now && m_buttons[b]) m_released[b] = 1'b1;
                m_buttons[b] = held_now;
            end else begin
                m_buttons[b] = 1'b0;
            end
        end
        m_present = pad;
        m_timeout = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        obs_irq  += int'(irq);
        obs_busy += int'(busy);
    endtask

    task automatic apply_clr(input logic [15:0] mask);
        @(negedge clk); ev_clr = mask;
        @(negedge clk); ev_clr = '0;
        m_pressed  &= ~mask;
        m_released &= ~mask;
    endtask

    // Issue poll_req, act as the pad reader (optionally), wait for idle.
    task automatic run_poll(input logic [15:0] ns, input bit respond, input int delay, input int hold,
                            input logic [15:0] cap_clr, output bit got_frame, output int frame_w);
        got_frame = 1'b0; frame_w = 0; obs_irq = 0; obs_busy = 0;
        @(negedge clk); poll_req = 1'b1;
        @(negedge clk); poll_req = 1'b0;
        for (int i = 0; i < 10 && !got_frame; i++) begin
            if (frame === 1'b1) got_frame = 1'b1;
            else step();
        end
        obs_busy = 0;
        while (frame === 1'b1 && frame_w < 10) begin
            frame_w++;
            step();
        end
        if (respond) begin
            repeat (delay) step();
            nes_state = ns; done = 1'b1;
            step(); ev_clr = cap_clr;
            step(); ev_clr = '0;
            repeat (hold - 2) step();
            done = 1'b0; nes_state = 16'($urandom);
            repeat (4) step();
        end
        for (int g = 0; g < 6000 && busy === 1'b1; g++) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({frame, busy, irq, present, timeout_err, buttons, pressed_ev, released_ev} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {frame, busy, irq, present, timeout_err, buttons, pressed_ev, released_ev});
        end
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b frame=%b expected 0 0", busy, frame);
        end
    endtask

    task automatic test_press();
        bit gf, ei; int fw;
        model_capture(16'h7FFF, 16'h0000, ei);
        run_poll(16'h7FFF, 1'b1, 3, 4, 16'h0000, gf, fw);
        checks++; if (!gf || fw != 1) begin errors++; $display("FAIL press_frame: seen=%0d width=%0d expected 1 1", gf, fw); end
        checks++; if (buttons !== m_buttons) begin errors++; $display("FAIL press_buttons: got %h expected %h", buttons, m_buttons); end
        checks++; if (pressed_ev !== m_pressed) begin errors++; $display("FAIL press_pressed_ev: got %h expected %h", pressed_ev, m_pressed); end
        checks++; if (released_ev !== m_released) begin errors++; $display("FAIL press_released_ev: got %h expected %h", released_ev, m_released); end
        checks++; if (obs_irq != int'(ei)) begin errors++; $display("FAIL press_irq: got %0d pulses expected %0d", obs_irq, ei); end
        checks++; if (present !== 1'b1) begin errors++; $display("FAIL press_present: got %b expected 1", present); end
    endtask

    task automatic test_release_and_clear();
        bit gf, ei; int fw;
        model_capture(16'hFFFF, 16'h0000, ei);
        run_poll(16'hFFFF, 1'b1, 0, 3, 16'h0000, gf, fw);
        checks++; if (buttons !== m_buttons) begin errors++; $display("FAIL release_buttons: got %h expected %h", buttons, m_buttons); end
        checks++; if (released_ev !== m_released) begin errors++; $display("FAIL release_released_ev: got %h expected %h", released_ev, m_released); end
        checks++; if (pressed_ev !== m_pressed) begin errors++; $display("FAIL release_pressed_ev: got %h expected %h", pressed_ev, m_pressed); end
        checks++; if (obs_irq != int'(ei)) begin errors++; $display("FAIL release_irq: got %0d pulses expected %0d", obs_irq, ei); end
        apply_clr(16'hFFFF);
        checks++;
        if (pressed_ev !== m_pressed || released_ev !== m_released) begin
            errors++;
            $display("FAIL clear_events: got %h/%h expected %h/%h", pressed_ev, released_ev, m_pressed, m_released);
        end
    endtask

    task automatic test_timeout();
        bit gf, ei; int fw;
        model_capture(16'h5A5F, 16'h0000, ei);
        run_poll(16'h5A5F, 1'b1, 2, 5, 16'h0000, gf, fw);
        run_poll(16'h0000, 1'b0, 0, 0, 16'h0000, gf, fw);
        m_timeout = 1'b1;
        checks++; if (obs_busy != 4096) begin errors++; $display("FAIL timeout_wait_cycles: got %0d expected 4096", obs_busy); end
        checks++; if (timeout_err !== m_timeout) begin errors++; $display("FAIL timeout_flag: got %b expected %b", timeout_err, m_timeout); end
        checks++; if (buttons !== m_buttons) begin errors++; $display("FAIL timeout_buttons: got %h expected %h", buttons, m_buttons); end
        checks++;
        if (pressed_ev !== m_pressed || released_ev !== m_released) begin
            errors++;
            $display("FAIL timeout_events: got %h/%h expected %h/%h", pressed_ev, released_ev, m_pressed, m_released);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        model_capture(16'h5A5F, 16'h0000, ei);
        run_poll(16'h5A5F, 1'b1, 1, 3, 16'h0000, gf, fw);
        checks++; if (timeout_err !== m_timeout) begin errors++; $display("FAIL timeout_cleared: got %b expected %b", timeout_err, m_timeout); end
    endtask

    task automatic test_no_pad();
        bit gf, ei; int fw;
        apply_clr(16'hFFFF);
        model_capture(16'h0000, 16'h0000, ei);
        run_poll(16'h0000, 1'b1, 4, 4, 16'h0000, gf, fw);
        checks++; if (present !== m_present) begin errors++; $display("FAIL nopad_present: got %b expected %b", present, m_present); end
        checks++; if (buttons !== m_buttons) begin errors++; $display("FAIL nopad_buttons: got %h expected %h", buttons, m_buttons); end
        checks++;
        if (pressed_ev !== m_pressed || released_ev !== m_released || obs_irq != int'(ei)) begin
            errors++;
            $display("FAIL nopad_events: got %h/%h irq %0d expected %h/%h irq %0d",
                     pressed_ev, released_ev, obs_irq, m_pressed, m_released, ei);
        end
    endtask

    task automatic test_random();
        bit gf, ei; int fw;
        logic [15:0] ns, cc;
        for (int it = 0; it < 24; it++) begin
            ns = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ns[3:0] = 4'hF;
            cc = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
            model_capture(ns, cc, ei);
            run_poll(ns, 1'b1, $urandom_range(0, 12), $urandom_range(3, 7), cc, gf, fw);
            checks++; if (!gf || fw != 1) begin errors++; $display("FAIL rand_frame[%0d]: seen=%0d width=%0d expected 1 1", it, gf, fw); end
            checks++; if (buttons !== m_buttons) begin errors++; $display("FAIL rand_buttons[%0d]: got %h expected %h", it, buttons, m_buttons); end
            checks++; if (pressed_ev !== m_pressed) begin errors++; $display("FAIL rand_pressed_ev[%0d]: got %h expected %h", it, pressed_ev, m_pressed); end
            checks++; if (released_ev !== m_released) begin errors++; $display("FAIL rand_released_ev[%0d]: got %h expected %h", it, released_ev, m_released); end
            checks++; if (present !== m_present) begin errors++; $display("FAIL rand_present[%0d]: got %b expected %b", it, present, m_present); end
            checks++; if (obs_irq != int'(ei)) begin errors++; $display("FAIL rand_irq[%0d]: got %0d pulses expected %0d", it, obs_irq, ei); end
            if ($urandom_range(0, 2) == 0) begin
                apply_clr(16'($urandom));
                checks++;
                if (pressed_ev !== m_pressed || released_ev !== m_released) begin
                    errors++;
                    $display("FAIL rand_clear[%0d]: got %h/%h expected %h/%h", it, pressed_ev, released_ev, m_pressed, m_released);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit gf, ei; int fw;
        int busy_seen;
        model_capture(16'h3CCF, 16'h0000, ei);
        run_poll(16'h3CCF, 1'b1, 0, 3, 16'h0000, gf, fw);
        @(negedge clk); poll_req = 1'b1;
        @(negedge clk); poll_req = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstwait_in_wait: busy=%b expected 1", busy); end
        reset = 1'b0;
        #1;
        checks++;
        if ({frame, busy, irq, present, timeout_err, buttons, pressed_ev, released_ev} !== '0) begin
            errors++;
            $display("FAIL rstwait_outputs: got %h expected 0",
                     {frame, busy, irq, present, timeout_err, buttons, pressed_ev, released_ev});
        end
        @(negedge clk); reset = 1'b1;
        model_reset();
        busy_seen = 0;
        repeat (2) begin @(negedge clk); busy_seen += int'(busy); end
        nes_state = 16'h7FFF; done = 1'b1;
        repeat (4) begin @(negedge clk); busy_seen += int'(busy); end
        done = 1'b0;
        repeat (5) begin @(negedge clk); busy_seen += int'(busy); end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL rstwait_stray_busy: got %0d busy cycles expected 0", busy_seen); end
        checks++;
        if (buttons !== m_buttons || pressed_ev !== m_pressed || present !== m_present) begin
            errors++;
            $display("FAIL rstwait_no_capture: got %h/%h/%b expected %h/%h/%b",
                     buttons, pressed_ev, present, m_buttons, m_pressed, m_present);
        end
    endtask

    task automatic test_tick_pending();
        int frames[$];
        int ds, irq_cnt;
        int exp_frames[4] = '{100, 106, 200, 300};
        ds = -1000; irq_cnt = 0;
        @(negedge clk); reset_t = 1'b1;
        for (int n = 1; n <= 320; n++) begin
            @(negedge clk);
            if (frame_t === 1'b1) begin
                frames.push_back(n);
                ds = n + 3;
            end
            done_t     = (n >= ds && n < ds + 4);
            poll_req_t = (n == 102 || n == 104);
            irq_cnt   += int'(irq_t);
        end
        checks++; if (frames.size() != 4) begin errors++; $display("FAIL tick_frame_count: got %0d expected 4", frames.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= frames.size() || frames[k] != exp_frames[k]) begin
                errors++;
                $display("FAIL tick_frame_time[%0d]: got %0d expected %0d", k,
                         (k < frames.size()) ? frames[k] : -1, exp_frames[k]);
            end
        end
        checks++; if (irq_cnt != 1) begin errors++; $display("FAIL tick_irq: got %0d pulses expected 1", irq_cnt); end
        checks++;
        if (buttons_t !== 16'h8000 || pressed_ev_t !== 16'h8000 || released_ev_t !== 16'h0000 ||
            present_t !== 1'b1 || timeout_err_t !== 1'b0 || busy_t !== 1'b0) begin
            errors++;
            $display("FAIL tick_final: got %h/%h/%h/%b/%b/%b expected 8000/8000/0000/1/0/0",
                     buttons_t, pressed_ev_t, released_ev_t, present_t, timeout_err_t, busy_t);
        end
    endtask

    initial begin
        reset = 1'b0; done = 1'b0; poll_req = 1'b0; nes_state = '1; ev_clr = '0;
        reset_t = 1'b0; done_t = 1'b0; poll_req_t = 1'b0; nes_state_t = 16'h7FFF; ev_clr_t = '0;
        obs_irq = 0; obs_busy = 0;
        model_reset();
        test_reset();
        test_press();
        test_release_and_clear();
        test_timeout();
        test_no_pad();
        test_random();
        test_reset_mid_wait();
        test_tick_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
